// File: rtl/sram_mixed.sv
// Behavioural view of the single-port, read-first SRAM macro.
// One access per rising edge; dout is registered and a write returns the old word.
module sram_mixed #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Unknown we drives dout to X and leaves mem untouched; an unknown addr
    // matches no word on the per-word write compare and reads back as X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (we)
                1'b1: begin
                    dout <= mem[addr];
                    for (int i = 0; i < DEPTH; i++) begin
                        if (addr == ADDR_WIDTH'(i)) begin
                            mem[i] <= din;
                        end
                    end
                end
                1'b0: begin
                    dout <= mem[addr];
                end
                default: begin
                    dout <= 'x;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mixed.sv
// Scoreboard bench for sram_mixed: the driver queues the expected dout per access,
// a monitor pops and compares after each rising edge.
module tb_sram_mixed;

    logic       clk;
    logic       rst;
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    int checks;
    int errors;

    logic [7:0]  exp_q  [$];
    string       name_q [$];

    sram_mixed #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .addr (addr),
        .din  (din),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic access(input logic w, input logic [3:0] a, input logic [7:0] d,
                          input logic [7:0] exp, input string nm);
        @(negedge clk);
        we   = w;
        addr = a;
        din  = d;
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    task automatic direct_check(input logic [7:0] exp, input string nm);
        checks++;
        if (dout !== exp) begin
            errors++;
            $display("FAIL %s: dout=%h expected=%h", nm, dout, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            logic [7:0] e;
            string      n;
            #1;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (dout !== e) begin
                errors++;
                $display("FAIL %s: dout=%h expected=%h", n, dout, e);
            end
        end
    end

    function automatic logic [7:0] old_word(input int i);
        case (i)
            0:       return 8'h0F;
            3:       return 8'h55;
            5:       return 8'h12;
            15:      return 8'hF0;
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b1;
        we   = 1'b0;
        addr = '0;
        din  = '0;
        repeat (2) @(posedge clk);
        #1;
        direct_check(8'h00, "reset_state");
        @(negedge clk);
        rst = 1'b0;

        // Put a non-zero word on dout, then assert reset mid-cycle
        access(1'b1, 4'd2, 8'h33, 8'h00, "pre_write2");
        access(1'b0, 4'd2, 8'h00, 8'h33, "pre_read2");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        direct_check(8'h00, "async_reset_dout");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) access(1'b0, 4'(i), 8'h00, 8'h00, "reset_clear_read");

        access(1'b1, 4'd3, 8'hAA, 8'h00, "write3_old");
        access(1'b0, 4'd3, 8'h00, 8'hAA, "read3_AA");
        access(1'b1, 4'd3, 8'h55, 8'hAA, "readfirst3");
        access(1'b0, 4'd3, 8'h00, 8'h55, "read3_55");

        access(1'b1, 4'd0,  8'h0F, 8'h00, "write0_old");
        access(1'b1, 4'd15, 8'hF0, 8'h00, "write15_old");
        access(1'b0, 4'd0,  8'h00, 8'h0F, "read0");
        access(1'b0, 4'd15, 8'h00, 8'hF0, "read15");
        access(1'b0, 4'd3,  8'h00, 8'h55, "read3_isolated");

        access(1'b1, 4'd5, 8'h12, 8'h00, "write5_old");
        access(1'b0, 4'd5, 8'h00, 8'h12, "b2b_read5");

        for (int i = 0; i < 16; i++) begin
            access(1'b1, 4'(i), 8'(i * 8'h11), old_word(i), "alt_write_old");
            access(1'b0, 4'(i), 8'h00, 8'(i * 8'h11), "alt_read");
        end

        // Reset between edges wipes addr 7; a write under reset is dropped
        access(1'b1, 4'd7, 8'h77, 8'h77, "write7");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        direct_check(8'h00, "mid_op_reset_dout");
        @(negedge clk);
        we   = 1'b1;
        addr = 4'd7;
        din  = 8'h99;
        @(posedge clk);
        #1;
        direct_check(8'h00, "write_during_reset_dout");
        @(negedge clk);
        we  = 1'b0;
        rst = 1'b0;
        access(1'b0, 4'd7, 8'h00, 8'h00, "read7_after_reset");
        access(1'b0, 4'd15, 8'h00, 8'h00, "read15_after_reset");

        begin
            int budget;
            budget = 0;
            while (exp_q.size() > 0 && budget < 100) begin
                @(posedge clk);
                budget++;
            end
            #2;
            if (exp_q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
